// File: rtl/seg7_pkg.sv
// Shared glyph constants and pattern classification types for the 7-segment
// capture path and the display driver's self-test.
package seg7_pkg;

  localparam int SYNC_STAGES = 2;

  // Active-low gfedcba, bit0 = segment a.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_OVF   = 7'b0110110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    KIND_HEX,
    KIND_OVF,
    KIND_BLANK,
    KIND_ERR
  } seg_kind_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational classifier: active-low segment pattern to glyph kind and,
// for hex glyphs, the nibble it shows.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output seg_kind_t  kind,
  output logic [3:0] nibble
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    kind   = KIND_HEX;
    nibble = 4'h0;
    case (pattern)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_OVF:   kind   = KIND_OVF;
      SEG_BLANK: kind   = KIND_BLANK;
      default:   kind   = KIND_ERR;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Reads back a multiplexed common-anode display: synchronizes the pins, waits
// for a stable dwell on one anode, then decodes and latches that digit.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   anode_in,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_ovf,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_done,
  output logic                    stale
);

  localparam int SW = NUM_DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SW-1:0]         sync_q [SYNC_STAGES];
  logic [SW-1:0]         sample;
  logic [SW-1:0]         prev_q;
  logic [CW-1:0]         count_q;
  logic                  armed_q;
  logic                  active;
  logic                  same;
  logic                  commit;
  logic [NUM_DIGITS-1:0] sel;
  logic [NUM_DIGITS-1:0] seen_q;
  logic [NUM_DIGITS-1:0] seen_base;
  logic [TW-1:0]         tmo_q;
  seg_kind_t             kind;
  logic [3:0]            nibble;

  assign sample = sync_q[SYNC_STAGES-1];
  assign active = $onehot(~sample[SW-1:7]);
  assign same   = (sample == prev_q);
  // Counter can only be non-zero after a run of identical active samples, so
  // prev_q holds the dwell pattern whenever commit is asserted.
  assign commit = armed_q && (count_q == CW'(STABLE_CYCLES - 1));
  assign sel    = ~prev_q[SW-1:7];
  assign stale  = (tmo_q == TW'(TIMEOUT_CYCLES));

  seg7_pattern_decode u_decode (
    .pattern (prev_q[6:0]),
    .kind    (kind),
    .nibble  (nibble)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the pre-edge values regardless of statement order.
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q  <= '0;
      count_q <= '0;
      armed_q <= 1'b0;
    end else begin
      sync_q[0] <= {anode_in, seg_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sample;
      if (clear) begin
        count_q <= '0;
        armed_q <= 1'b0;
      end else if (!active || !same) begin
        count_q <= '0;
        armed_q <= 1'b1;
      end else begin
        if (count_q != CW'(STABLE_CYCLES)) count_q <= count_q + 1'b1;
        if (commit) armed_q <= 1'b0;
      end
    end
  end

  always_comb begin
    seen_base = seen_q;
    if (&seen_q) seen_base = '0;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      digits      <= '0;
      digit_valid <= '0;
      digit_ovf   <= '0;
      digit_err   <= '0;
      frame_done  <= 1'b0;
      seen_q      <= '0;
      tmo_q       <= '0;
    end else begin
      frame_done <= &seen_q;
      seen_q     <= commit ? (seen_base | sel) : seen_base;
      if (commit) tmo_q <= '0;
      else if (!stale) tmo_q <= tmo_q + 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (commit && sel[i]) begin
          digit_valid[i] <= (kind == KIND_HEX) || (kind == KIND_OVF);
          digit_ovf[i]   <= (kind == KIND_OVF);
          digit_err[i]   <= (kind == KIND_ERR);
          if (kind == KIND_HEX) digits[4*i +: 4] <= nibble;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// Scoreboard bench for seg7_capture: a run-based reference model predicts the
// outputs after every edge, and a negedge monitor compares them with the DUT.
module tb_seg7_capture;

  localparam int ND   = 4;
  localparam int SC   = 4;
  localparam int TC   = 20;
  localparam int MAXE = 16384;
  localparam logic [6:0] OVF_G   = 7'b0110110;
  localparam logic [6:0] BLANK_G = 7'b1111111;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic [6:0]    seg_in = 7'b0000000;
  logic [ND-1:0] anode_in = 4'b1110;
  logic [4*ND-1:0] digits;
  logic [ND-1:0] digit_valid, digit_ovf, digit_err;
  logic          frame_done, stale;

  seg7_capture #(
    .NUM_DIGITS     (ND),
    .STABLE_CYCLES  (SC),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .anode_in    (anode_in),
    .clear       (clear),
    .digits      (digits),
    .digit_valid (digit_valid),
    .digit_ovf   (digit_ovf),
    .digit_err   (digit_err),
    .frame_done  (frame_done),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack_out(input logic [15:0] dg, input logic [3:0] v,
                                           input logic [3:0] o, input logic [3:0] e,
                                           input logic f, input logic s);
    return {2'b00, dg, v, o, e, f, s};
  endfunction

  function automatic int glyph_index(input logic [6:0] g);
    for (int i = 0; i < 16; i++) if (glyph[i] == g) return i;
    return -1;
  endfunction

  // Reference model: a pattern sampled on edges k..k+SC-1 that starts a new
  // run on one anode is committed on edge k+SC+2, unless rst/clear hits edges
  // k+2..k+SC+2.
  bit [10:0]   pin_h [MAXE];
  bit          kill_h [MAXE];
  int          t = 0;
  logic [15:0] m_dig = '0;
  logic [3:0]  m_val = '0, m_ovf = '0, m_err = '0, m_seen = '0;
  logic        m_fd = 1'b0;
  int          m_tmo = 0;
  logic [31:0] exp_q [$];

  always @(posedge clk) begin : model
    int k, d, idx;
    bit cm;
    bit [10:0] p;
    t++;
    if (t >= MAXE) begin
      $display("FAIL edge_budget: got %0d edges, expected fewer than %0d", t, MAXE);
      $fatal(1);
    end
    pin_h[t]  = rst ? 11'd0 : {anode_in, seg_in};
    kill_h[t] = rst || clear;
    cm = 1'b0;
    p  = '0;
    k  = t - SC - 2;
    if (k >= 1) begin
      p  = pin_h[k];
      cm = ($countones(~p[10:7]) == 1) && (pin_h[k-1] != p);
      for (int j = 1; j < SC; j++) if (pin_h[k+j] != p) cm = 1'b0;
      for (int j = k + 2; j <= t; j++) if (kill_h[j]) cm = 1'b0;
    end
    if (rst || clear) begin
      m_dig = '0; m_val = '0; m_ovf = '0; m_err = '0; m_seen = '0;
      m_fd = 1'b0; m_tmo = 0;
    end else begin
      m_fd = (m_seen == 4'hF);
      if (m_fd) m_seen = '0;
      if (cm) begin
        d = 0;
        for (int j = 0; j < ND; j++) if (!p[7+j]) d = j;
        idx = glyph_index(p[6:0]);
        m_seen[d] = 1'b1;
        m_tmo = 0;
        if (idx >= 0) begin
          m_dig[4*d +: 4] = idx[3:0];
          m_val[d] = 1'b1; m_ovf[d] = 1'b0; m_err[d] = 1'b0;
        end else if (p[6:0] == OVF_G) begin
          m_val[d] = 1'b1; m_ovf[d] = 1'b1; m_err[d] = 1'b0;
        end else if (p[6:0] == BLANK_G) begin
          m_val[d] = 1'b0; m_ovf[d] = 1'b0; m_err[d] = 1'b0;
        end else begin
          m_val[d] = 1'b0; m_ovf[d] = 1'b0; m_err[d] = 1'b1;
        end
      end else if (m_tmo < TC) begin
        m_tmo++;
      end
    end
    exp_q.push_back(pack_out(m_dig, m_val, m_ovf, m_err, m_fd, m_tmo == TC));
  end

  always @(negedge clk) begin : monitor
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: got no expected entry at edge %0d, expected one", t);
    end else begin
      check($sformatf("outputs@edge%0d", t),
            pack_out(digits, digit_valid, digit_ovf, digit_err, frame_done, stale),
            exp_q.pop_front());
    end
    if (frame_done === 1'b1) pulses++;
  end

  task automatic drive(input logic [3:0] an, input logic [6:0] sg, input int n);
    anode_in = an;
    seg_in   = sg;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  int         sg_idx [4] = '{3, 10, 13, 15};

  initial begin : stimulus
    int n, p0, r, sel_g, len;
    logic [3:0] an;
    logic [6:0] sg;

    // Reset with digit 0 showing 8 on the pins.
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", pack_out(digits, digit_valid, digit_ovf, digit_err, frame_done, stale), 32'd0);
    rst = 1'b0;
    n = 0;
    while (n <= 20) begin
      @(posedge clk);
      #1;
      n++;
      if (digit_valid[0] === 1'b1) break;
    end
    check("commit_latency_edges", n, 7);
    check("reset_digit0", {28'd0, digits[3:0]}, 32'h8);
    drive(4'b1110, 7'b0000000, 5);

    // Two passes of a full scan.
    p0 = pulses;
    for (int i = 0; i < 4; i++) drive(an_tab[i], glyph[sg_idx[i]], 10);
    check("scan_digits", {16'd0, digits}, 32'hFDA3);
    check("scan_valid", {28'd0, digit_valid}, 32'hF);
    check("scan_pulses_pass1", pulses - p0, 1);
    for (int i = 0; i < 3; i++) drive(an_tab[i], glyph[sg_idx[i]], 10);
    check("scan_pulses_partial", pulses - p0, 1);
    drive(an_tab[3], glyph[sg_idx[3]], 10);
    check("scan_pulses_pass2", pulses - p0, 2);

    // Glitch rejection on digit 1.
    drive(4'b1101, glyph[5], 3);
    drive(4'b1101, 7'b0000000, 1);
    drive(4'b1101, glyph[5], 10);
    check("glitch_digit1", {28'd0, digits[7:4]}, 32'h5);
    check("glitch_valid1", {31'd0, digit_valid[1]}, 32'd1);

    // Overflow, error and blank on digit 2.
    drive(4'b1011, OVF_G, 10);
    check("ovf_flags2", {29'd0, digit_valid[2], digit_ovf[2], digit_err[2]}, 32'b110);
    check("ovf_nibble2", {28'd0, digits[11:8]}, 32'hD);
    drive(4'b1011, 7'b1010101, 10);
    check("err_flags2", {29'd0, digit_valid[2], digit_ovf[2], digit_err[2]}, 32'b001);
    drive(4'b1011, BLANK_G, 10);
    check("blank_flags2", {29'd0, digit_valid[2], digit_ovf[2], digit_err[2]}, 32'b000);
    check("blank_nibble2", {28'd0, digits[11:8]}, 32'hD);

    // Illegal anode patterns let the timeout run out.
    drive(4'b1100, glyph[2], 25);
    check("stale_two_anodes", {31'd0, stale}, 32'd1);
    drive(4'b1111, glyph[2], 25);
    check("stale_no_anode", {31'd0, stale}, 32'd1);
    drive(4'b1110, glyph[1], 10);
    check("stale_cleared", {31'd0, stale}, 32'd0);
    check("stale_digit0", {28'd0, digits[3:0]}, 32'h1);

    // Clear lands on the exact commit edge of digit 0.
    anode_in = 4'b1110;
    seg_in   = glyph[7];
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    drive(4'b1110, glyph[7], 12);
    check("clear_digits", {16'd0, digits}, 32'd0);
    check("clear_valid", {28'd0, digit_valid}, 32'd0);

    // Randomized dwells, anode patterns, glyphs and occasional clears.
    for (int s = 0; s < 150; s++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       an = ~(4'b0001 << $urandom_range(0, 3));
      else if (r == 7) an = 4'b1111;
      else             an = 4'($urandom_range(0, 15));
      sel_g = $urandom_range(0, 18);
      if (sel_g < 16)       sg = glyph[sel_g];
      else if (sel_g == 16) sg = OVF_G;
      else if (sel_g == 17) sg = BLANK_G;
      else                  sg = 7'($urandom_range(0, 127));
      len = $urandom_range(1, 12);
      anode_in = an;
      seg_in   = sg;
      clear    = ($urandom_range(0, 9) == 0);
      @(posedge clk);
      #1;
      clear = 1'b0;
      drive(an, sg, len - 1);
    end

    drive(4'b1111, BLANK_G, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
